// File: rtl/serial_slt_unit_if.sv
// Request/response bundle for serial_slt_unit.
// The eq flag exists only when SERIAL_SLT_EQ_FLAG_EN is defined.
interface serial_slt_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             is_unsigned;
  logic             busy;
  logic             done;
  logic             lt;
  logic [WIDTH-1:0] diff;
  logic             ovf;
`ifdef SERIAL_SLT_EQ_FLAG_EN
  logic             eq;

  modport master (
    output start, a, b, is_unsigned,
    input  busy, done, lt, diff, ovf, eq
  );
  modport slave (
    input  start, a, b, is_unsigned,
    output busy, done, lt, diff, ovf, eq
  );
`else
  modport master (
    output start, a, b, is_unsigned,
    input  busy, done, lt, diff, ovf
  );
  modport slave (
    input  start, a, b, is_unsigned,
    output busy, done, lt, diff, ovf
  );
`endif
endinterface

// File: rtl/serial_slt_unit.sv
// Digit-serial A-B compare producing the SLT/SLTU bit, full difference and signed overflow.
// Optional eq flag (diff == 0) is enabled by defining SERIAL_SLT_EQ_FLAG_EN.
module serial_slt_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_slt_unit_if.slave  bus
);
  localparam int unsigned NDIG  = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, nb_q, nb_d, sh_q, sh_d, diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d, uns_q, uns_d;
  logic             busy_q, busy_d, done_q, done_d, lt_q, lt_d, ovf_q, ovf_d;
`ifdef SERIAL_SLT_EQ_FLAG_EN
  logic             sticky_q, sticky_d, eq_q, eq_d;
`endif

  logic [DIGIT:0]   dsum_c;
  logic             cout_c, cin_msb_c;
  logic [WIDTH-1:0] sh_next_c;

  // One digit of A + ~B + carry; carry into the digit MSB recovered from the sum bit.
  assign dsum_c    = {1'b0, a_q[DIGIT-1:0]} + {1'b0, nb_q[DIGIT-1:0]} + (DIGIT+1)'(carry_q);
  assign cout_c    = dsum_c[DIGIT];
  assign cin_msb_c = dsum_c[DIGIT-1] ^ a_q[DIGIT-1] ^ nb_q[DIGIT-1];
  assign sh_next_c = WIDTH'({dsum_c[DIGIT-1:0], sh_q} >> DIGIT);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    nb_d    = nb_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    uns_d   = uns_q;
    diff_d  = diff_q;
    lt_d    = lt_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
`ifdef SERIAL_SLT_EQ_FLAG_EN
    sticky_d = sticky_q;
    eq_d     = eq_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          nb_d    = ~bus.b;
          uns_d   = bus.is_unsigned;
          carry_d = 1'b1;
          cnt_d   = '0;
          sh_d    = '0;
`ifdef SERIAL_SLT_EQ_FLAG_EN
          sticky_d = 1'b0;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        sh_d    = sh_next_c;
        carry_d = cout_c;
        a_d     = a_q >> DIGIT;
        nb_d    = nb_q >> DIGIT;
        cnt_d   = cnt_q + CNT_W'(1);
`ifdef SERIAL_SLT_EQ_FLAG_EN
        sticky_d = sticky_q | (|dsum_c[DIGIT-1:0]);
`endif
        // Results are registered on the last digit so they are valid alongside done.
        if (cnt_q == CNT_W'(NDIG - 1)) begin
          state_d = FINISH;
          done_d  = 1'b1;
          diff_d  = sh_next_c;
          ovf_d   = cin_msb_c ^ cout_c;
          lt_d    = uns_q ? ~cout_c : (dsum_c[DIGIT-1] ^ cin_msb_c ^ cout_c);
`ifdef SERIAL_SLT_EQ_FLAG_EN
          eq_d    = ~sticky_d;
`endif
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      nb_q    <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      uns_q   <= 1'b0;
      diff_q  <= '0;
      lt_q    <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_SLT_EQ_FLAG_EN
      sticky_q <= 1'b0;
      eq_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      nb_q    <= nb_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      uns_q   <= uns_d;
      diff_q  <= diff_d;
      lt_q    <= lt_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_SLT_EQ_FLAG_EN
      sticky_q <= sticky_d;
      eq_q     <= eq_d;
`endif
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.lt   = lt_q;
  assign bus.diff = diff_q;
  assign bus.ovf  = ovf_q;
`ifdef SERIAL_SLT_EQ_FLAG_EN
  assign bus.eq   = eq_q;
`endif
endmodule

// File: tb/tb_serial_slt_unit.sv
// Directed bench for serial_slt_unit: DIGIT=1 and DIGIT=4 instances share clock and reset.
// eq checks are included when SERIAL_SLT_EQ_FLAG_EN is defined.
module tb_serial_slt_unit;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_slt_unit_if #(.WIDTH(W)) b1 ();
  serial_slt_unit_if #(.WIDTH(W)) b4 ();

  serial_slt_unit #(.WIDTH(W), .DIGIT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  serial_slt_unit #(.WIDTH(W), .DIGIT(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));

  int total = 0;
  int bad   = 0;
  int nbusy, ndone, done_at;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request on the DIGIT=1 unit and watch it until busy drops.
  // A non-zero poke_at injects a conflicting start (a=9, b=3) at that cycle.
  task automatic run1(input logic [W-1:0] a, input logic [W-1:0] b, input logic u,
                      input int poke_at, output int nb, output int nd, output int dat);
    @(negedge clk);
    b1.a = a; b1.b = b; b1.is_unsigned = u; b1.start = 1'b1;
    @(negedge clk);
    b1.start = 1'b0;
    nb = 0; nd = 0; dat = 0;
    for (int i = 1; i <= 60; i++) begin
      if (b1.busy) nb++;
      if (b1.done) begin nd++; dat = i; end
      if (!b1.busy) break;
      if (i == poke_at) begin
        b1.a = 32'd9; b1.b = 32'd3; b1.is_unsigned = 1'b1; b1.start = 1'b1;
      end else begin
        b1.start = 1'b0;
      end
      @(negedge clk);
    end
    b1.start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    b1.start = 1'b0; b1.a = '0; b1.b = '0; b1.is_unsigned = 1'b0;
    b4.start = 1'b0; b4.a = '0; b4.b = '0; b4.is_unsigned = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", W'(b1.busy), 32'd0);
    chk("rst_done", W'(b1.done), 32'd0);
    chk("rst_lt",   W'(b1.lt),   32'd0);
    chk("rst_diff", b1.diff,     32'd0);
    chk("rst_ovf",  W'(b1.ovf),  32'd0);
`ifdef SERIAL_SLT_EQ_FLAG_EN
    chk("rst_eq",   W'(b1.eq),   32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Signed basic: 5 - 7
    run1(32'd5, 32'd7, 1'b0, 0, nbusy, ndone, done_at);
    chk("basic_busy_cycles", W'(nbusy), 32'd33);
    chk("basic_done_count",  W'(ndone), 32'd1);
    chk("basic_done_at",     W'(done_at), 32'd33);
    chk("basic_lt",   W'(b1.lt),  32'd1);
    chk("basic_diff", b1.diff,    32'hFFFF_FFFE);
    chk("basic_ovf",  W'(b1.ovf), 32'd0);
`ifdef SERIAL_SLT_EQ_FLAG_EN
    chk("basic_eq",   W'(b1.eq),  32'd0);
`endif

    // 0xFFFFFFFF vs 1, unsigned then signed
    run1(32'hFFFF_FFFF, 32'd1, 1'b1, 0, nbusy, ndone, done_at);
    chk("u_big_lt",   W'(b1.lt), 32'd0);
    chk("u_big_diff", b1.diff,   32'hFFFF_FFFE);
    run1(32'hFFFF_FFFF, 32'd1, 1'b0, 0, nbusy, ndone, done_at);
    chk("s_neg1_lt",  W'(b1.lt),  32'd1);
    chk("s_neg1_ovf", W'(b1.ovf), 32'd0);

    // Overflow: 0x80000000 - 1
    run1(32'h8000_0000, 32'd1, 1'b0, 0, nbusy, ndone, done_at);
    chk("ovf_diff", b1.diff,    32'h7FFF_FFFF);
    chk("ovf_ovf",  W'(b1.ovf), 32'd1);
    chk("ovf_lt",   W'(b1.lt),  32'd1);
    run1(32'h8000_0000, 32'd1, 1'b1, 0, nbusy, ndone, done_at);
    chk("ovf_u_lt", W'(b1.lt),  32'd0);

    // Unsigned, a > b
    run1(32'd7, 32'd5, 1'b1, 0, nbusy, ndone, done_at);
    chk("u_gt_lt",   W'(b1.lt), 32'd0);
    chk("u_gt_diff", b1.diff,   32'd2);

    // Busy protection: conflicting start at cycle 10 must be ignored
    run1(32'd3, 32'd9, 1'b0, 10, nbusy, ndone, done_at);
    chk("busyprot_lt",    W'(b1.lt), 32'd1);
    chk("busyprot_diff",  b1.diff,   32'hFFFF_FFFA);
    chk("busyprot_done",  W'(ndone), 32'd1);
    repeat (3) @(negedge clk);
    chk("busyprot_idle",  W'(b1.busy), 32'd0);

    // Reset mid-operation
    @(negedge clk);
    b1.a = 32'h8000_0000; b1.b = 32'd1; b1.is_unsigned = 1'b0; b1.start = 1'b1;
    @(negedge clk);
    b1.start = 1'b0;
    repeat (14) @(negedge clk);
    chk("midrst_busy_before", W'(b1.busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy", W'(b1.busy), 32'd0);
    chk("midrst_lt",   W'(b1.lt),   32'd0);
    chk("midrst_diff", b1.diff,     32'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (b1.done) ndone++;
    end
    chk("midrst_no_done", W'(ndone), 32'd0);
    run1(32'd42, 32'd42, 1'b0, 0, nbusy, ndone, done_at);
    chk("eqops_done", W'(ndone), 32'd1);
    chk("eqops_lt",   W'(b1.lt),  32'd0);
    chk("eqops_diff", b1.diff,    32'd0);
    chk("eqops_ovf",  W'(b1.ovf), 32'd0);
`ifdef SERIAL_SLT_EQ_FLAG_EN
    chk("eqops_eq",   W'(b1.eq),  32'd1);
`endif

    // DIGIT=4 instance: 0x10 - 0x20 signed
    @(negedge clk);
    b4.a = 32'h10; b4.b = 32'h20; b4.is_unsigned = 1'b0; b4.start = 1'b1;
    @(negedge clk);
    b4.start = 1'b0;
    ndone = 0; done_at = 0; nbusy = 0;
    for (int i = 1; i <= 30; i++) begin
      if (b4.busy) nbusy++;
      if (b4.done) begin ndone++; done_at = i; end
      @(negedge clk);
    end
    chk("d4_done_at", W'(done_at), 32'd9);
    chk("d4_done_count", W'(ndone), 32'd1);
    chk("d4_busy_cycles", W'(nbusy), 32'd9);
    chk("d4_lt",   W'(b4.lt),  32'd1);
    chk("d4_diff", b4.diff,    32'hFFFF_FFF0);
    chk("d4_ovf",  W'(b4.ovf), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
